// File: rtl/gpipe_raster_arbiter.sv
// Round-robin arbiter sharing one rasterizer command port among NUM_REQ dispatchers, locked per triangle.
// Optional lock watchdog: define GPIPE_ARB_TIMEOUT_EN to enable it (limit set by TIMEOUT_CYCLES).
module gpipe_raster_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [3*NUM_REQ-1:0]       req_type,
    input  logic [32*NUM_REQ-1:0]      req_x,
    input  logic [32*NUM_REQ-1:0]      req_y,
    output logic                       rast_valid,
    input  logic                       rast_ready,
    output logic [2:0]                 rast_type,
    output logic [31:0]                rast_x,
    output logic [31:0]                rast_y,
    output logic [$clog2(NUM_REQ)-1:0] rast_src,
    output logic                       locked,
    output logic                       lock_timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CW    = IDX_W + 1;

    localparam logic [2:0] T_SET_V0 = 3'd1;
    localparam logic [2:0] T_SET_V2 = 3'd3;
    localparam logic [2:0] T_DRAW   = 3'd4;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("gpipe_raster_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] next_ptr;
    logic [CW-1:0]    cand;
    logic             win_found;
    logic             slot_free;
    logic             acc;
    logic [2:0]       sel_type;
    logic [31:0]      sel_x;
    logic [31:0]      sel_y;

    // Handshake: a command moves on a port in any cycle where its valid and ready are
    // both high at the rising edge; ready never depends on the command payload.
    assign slot_free = !rast_valid || rast_ready;
    assign locked    = (state_q == ST_LOCKED);

    // Winner: the owner while locked, otherwise first valid requester from rr_ptr upward.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        if (state_q == ST_LOCKED) begin
            win_found = 1'b1;
            win_idx   = owner_q;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = {1'b0, rr_ptr_q} + CW'(k);
                if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
                if (!win_found && req_valid[cand[IDX_W-1:0]]) begin
                    win_found = 1'b1;
                    win_idx   = cand[IDX_W-1:0];
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (win_found && slot_free) req_ready[win_idx] = 1'b1;
    end

    assign acc      = win_found && slot_free && req_valid[win_idx];
    assign next_ptr = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

    always_comb begin
        sel_type = '0;
        sel_x    = '0;
        sel_y    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                sel_type = req_type[3*i +: 3];
                sel_x    = req_x[32*i +: 32];
                sel_y    = req_y[32*i +: 32];
            end
        end
    end

`ifdef GPIPE_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0]  wd_cnt_q;
    logic [IDX_W-1:0] owner_next;
    logic             wd_hit;

    // Fires on the edge that would make the idle-owner count reach TIMEOUT_CYCLES.
    assign wd_hit     = (state_q == ST_LOCKED) && !acc && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
    assign owner_next = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q     <= '0;
            lock_timeout <= 1'b0;
        end else begin
            lock_timeout <= wd_hit;
            if (state_q != ST_LOCKED || acc || wd_hit) wd_cnt_q <= '0;
            else                                       wd_cnt_q <= wd_cnt_q + 1'b1;
        end
    end
`else
    assign lock_timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        if (acc) begin
            case (state_q)
                ST_IDLE: begin
                    if (sel_type >= T_SET_V0 && sel_type <= T_SET_V2) begin
                        state_d = ST_LOCKED;
                        owner_d = win_idx;
                    end else begin
                        rr_ptr_d = next_ptr;
                    end
                end
                ST_LOCKED: begin
                    if (sel_type == T_DRAW) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = next_ptr;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
`ifdef GPIPE_ARB_TIMEOUT_EN
        if (wd_hit) begin
            state_d  = ST_IDLE;
            rr_ptr_d = owner_next;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
        end
    end

    // Output stage reloads on any accept, even while draining, for one command per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rast_valid <= 1'b0;
            rast_type  <= '0;
            rast_x     <= '0;
            rast_y     <= '0;
            rast_src   <= '0;
        end else if (acc) begin
            rast_valid <= 1'b1;
            rast_type  <= sel_type;
            rast_x     <= sel_x;
            rast_y     <= sel_y;
            rast_src   <= win_idx;
        end else if (rast_ready) begin
            rast_valid <= 1'b0;
        end
    end

endmodule
